// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
//   Turns N synchronised level inputs into one-shot rising-edge events, latches
//   each as pending and serialises pending events round-robin to a single
//   consumer over a valid/ready handshake.
//   Optional feature macro: PULSE_EVENT_ARBITER_DEBOUNCE_EN (per-channel
//   debounce filter of DEB_CYCLES clocks ahead of the edge detector).
module pulse_event_arbiter #(
    parameter int N          = 4,
    parameter int IDW        = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   lvl,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    input  logic           evt_ready,
    output logic [N-1:0]   pend,
    output logic [N-1:0]   overrun,
    input  logic           ovr_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           evt_valid_q, evt_valid_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   overrun_q, overrun_d;
    logic [N-1:0]   prev_q, prev_d;

    logic [N-1:0]   lvl_f_s;
    logic [N-1:0]   edge_s;
    logic [N-1:0]   gnt_s;
    logic [N-1:0]   ovr_set_s;
    logic [IDW-1:0] win_s;
    logic           found_s;

`ifdef PULSE_EVENT_ARBITER_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [N-1:0]  lvl_f_q, lvl_f_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // Debounce: the filtered level follows lvl only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        lvl_f_d = lvl_f_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (lvl[i] != lvl_f_q[i]) begin
                if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    lvl_f_d[i] = lvl[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounce registers: filtered levels and stability counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_f_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lvl_f_q <= lvl_f_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lvl_f_s = lvl_f_q;
`else
    assign lvl_f_s = lvl;
`endif

    // Round-robin search: first pending channel after rr_ptr, wrapping modulo N.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        found_s = 1'b0;
        win_s   = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            cand = IDW'(idx);
            if (!found_s && pend_q[cand]) begin
                found_s = 1'b1;
                win_s   = cand;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM next state: leave IDLE when something is pending, leave OFFER on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: register the winner on grant, drop valid and advance rr_ptr on handshake.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_s       = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    evt_valid_d  = 1'b1;
                    evt_id_d     = win_s;
                    gnt_s[win_s] = 1'b1;
                end else begin
                    evt_valid_d = 1'b0;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = evt_id_q;
                end else begin
                    evt_valid_d = 1'b1;
                end
            end
            default: begin
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // Edge detect, pending set/clear and sticky overrun; a new edge beats a same-cycle grant clear.
    always_comb begin
        edge_s    = lvl_f_s & ~prev_q;
        prev_d    = lvl_f_s;
        pend_d    = (pend_q & ~gnt_s) | edge_s;
        ovr_set_s = edge_s & pend_q & ~gnt_s;
        if (ovr_clr) begin
            overrun_d = ovr_set_s;
        end else begin
            overrun_d = overrun_q | ovr_set_s;
        end
    end

    // State register: synchronous reset drops any offered and pending events.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= IDW'(N - 1);
            pend_q      <= '0;
            overrun_q   <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            prev_q      <= prev_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pend      = pend_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Testbench for pulse_event_arbiter: reference model + event scoreboard.
module tb_pulse_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int DEB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   lvl;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_ready;
    logic [N-1:0]   pend;
    logic [N-1:0]   overrun;
    logic           ovr_clr;

    pulse_event_arbiter #(.N(N), .IDW(IDW), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .lvl       (lvl),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pend      (pend),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int fails  = 0;
    int hs_cnt = 0;
    int exp_q[$];

    // reference model state (what the registers should hold after the last edge)
    bit [N-1:0] m_prev, m_pend, m_ovr, m_lvlf;
    int         m_rr;
    bit         m_offer;
    int         m_id;
    int         m_cnt [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // behavioural model: applies the arbitration rules once per rising edge
    initial begin
        forever begin
            bit [N-1:0] lf, e, pn, setv;
            bit         keep;
            int         g, best, d;
            @(posedge clk);
            if (rst) begin
                m_prev = '0; m_pend = '0; m_ovr = '0; m_lvlf = '0;
                m_rr = N - 1; m_offer = 1'b0; m_id = 0;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
                exp_q.delete();
            end else begin
`ifdef PULSE_EVENT_ARBITER_DEBOUNCE_EN
                lf = m_lvlf;
`else
                lf = lvl;
`endif
                e = lf & ~m_prev;
                g = -1; best = N;
                if (!m_offer) begin
                    for (int i = 0; i < N; i++) begin
                        if (m_pend[i]) begin
                            d = (i - m_rr - 1 + 2 * N) % N;
                            if (d < best) begin best = d; g = i; end
                        end
                    end
                end
                pn = '0; setv = '0;
                for (int i = 0; i < N; i++) begin
                    keep    = m_pend[i] && (i != g);
                    pn[i]   = keep || e[i];
                    setv[i] = e[i] && keep;
                end
                m_ovr = (ovr_clr ? '0 : m_ovr) | setv;
                if (g >= 0) begin
                    m_offer = 1'b1; m_id = g; exp_q.push_back(g);
                end else if (m_offer && evt_ready) begin
                    m_offer = 1'b0; m_rr = m_id;
                end
                m_pend = pn;
                m_prev = lf;
                for (int i = 0; i < N; i++) begin
                    if (lvl[i] != m_lvlf[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == DEB) begin m_lvlf[i] = lvl[i]; m_cnt[i] = 0; end
                    end else begin
                        m_cnt[i] = 0;
                    end
                end
            end
        end
    end

    // monitor: compares registered outputs mid-cycle and scores each handshake
    initial begin
        forever begin
            int e_id;
            @(negedge clk);
            check("pend", pend, m_pend);
            check("overrun", overrun, m_ovr);
            check("evt_valid", evt_valid, m_offer);
            if (m_offer) check("evt_id_held", evt_id, m_id);
            if (!rst && evt_valid && evt_ready) begin
                hs_cnt++;
                check("event_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_id = exp_q.pop_front();
                    check("handshake_id", evt_id, e_id);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lvl = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int h;
        int got[$];
        rst = 1'b1; lvl = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        check("rst_valid", evt_valid, 0);
        check("rst_pend", pend, 0);
        check("rst_overrun", overrun, 0);
        check("rst_id", evt_id, 0);
        rst = 1'b0;

`ifndef PULSE_EVENT_ARBITER_DEBOUNCE_EN
        // single rising edge on channel 2: pend next edge, offer the edge after
        evt_ready = 1'b1;
        repeat (9) tick();
        h = hs_cnt;
        lvl = 4'b0100;
        tick();
        check("lat_pend2", pend, 4'b0100);
        check("lat_valid_early", evt_valid, 0);
        tick();
        check("lat_valid", evt_valid, 1);
        check("lat_id", evt_id, 2);
        check("lat_pend_clr", pend, 0);
        repeat (10) tick();
        check("single_event", hs_cnt - h, 1);

        // all four rise together after reset: ids 0,1,2,3 one per two cycles
        do_reset();
        lvl = 4'b1111;
        got.delete();
        repeat (12) begin
            tick();
            if (evt_valid) got.push_back(int'(evt_id));
        end
        check("burst_count", got.size(), 4);
        for (int j = 0; j < got.size(); j++) check("burst_order", got[j], j);
        check("burst_overrun", overrun, 0);

        // held offer on channel 1, two re-edges: merge into pend then overrun
        do_reset();
        evt_ready = 1'b0;
        lvl = 4'b0010;
        tick(); tick();
        check("ovr_offer_id", evt_id, 1);
        lvl = 4'b0000; tick();
        lvl = 4'b0010; tick();
        check("ovr_pend1", pend[1], 1);
        check("ovr_none_yet", overrun, 0);
        lvl = 4'b0000; tick();
        lvl = 4'b0010; tick();
        check("ovr_set", overrun, 4'b0010);
        check("ovr_id_stable", evt_id, 1);
        repeat (12) tick();
        ovr_clr = 1'b1; tick();
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        evt_ready = 1'b1;
        repeat (6) tick();

        // reset in the middle of an offer drops everything without a handshake
        do_reset();
        evt_ready = 1'b0;
        lvl = 4'b0111;
        tick(); tick();
        check("mid_valid", evt_valid, 1);
        check("mid_pend", pend, 4'b0110);
        h = hs_cnt;
        rst = 1'b1; lvl = '0; evt_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_pend", pend, 0);
        check("mid_rst_nohs", hs_cnt, h);
`else
        // glitch shorter than the window is filtered, a full window produces one event
        evt_ready = 1'b1;
        h = hs_cnt;
        lvl = 4'b0001; repeat (15) tick();
        lvl = 4'b0000; repeat (40) tick();
        check("deb_glitch", hs_cnt - h, 0);
        lvl = 4'b0001; repeat (40) tick();
        check("deb_event", hs_cnt - h, 1);
        lvl = 4'b0000; repeat (40) tick();
`endif

        // randomized traffic checked cycle by cycle against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
`ifdef PULSE_EVENT_ARBITER_DEBOUNCE_EN
                if ($urandom_range(0, 30) == 0) lvl[i] = ~lvl[i];
`else
                if ($urandom_range(0, 3) == 0) lvl[i] = ~lvl[i];
`endif
            end
            evt_ready = ($urandom_range(0, 2) != 0);
            ovr_clr   = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end

        // drain: no new edges, consumer always ready, nothing may be left
        rst = 1'b0; ovr_clr = 1'b0; evt_ready = 1'b1;
        repeat (4 * N + 2 * DEB + 8) tick();
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid", evt_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
